// File: rtl/spi_mem_master_pkg.sv
// Shared definitions for the SPI memory master: frame sizes, command bit
// polarity and FSM state encoding.
package spi_mem_master_pkg;

  localparam logic SPI_RW_READ  = 1'b1;
  localparam int   SPI_WR_BITS  = 16;
  localparam int   SPI_RD_BITS  = 17;
  localparam int   SPI_LAG_BITS = 1;
  localparam int   BYTE_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_mem_master_sclk_timer.sv
// Loadable down-counter shared by every timed FSM state; 'expire' marks the
// last cycle of the loaded interval.
module spi_mem_master_sclk_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             run,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  // Loaded with N-1 on state entry, so the state lasts exactly N cycles.
  assign expire = run && (cnt == '0);

endmodule

// File: rtl/spi_mem_master.sv
// Host-side SPI master issuing single-byte read/write frames to the spiMemory
// slave; one request at a time over a valid/ready handshake.
module spi_mem_master
  import spi_mem_master_pkg::*;
#(
  parameter int HALF     = 50,
  parameter int CS_SETUP = 50,
  parameter int CS_GAP   = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin
);

  localparam int CNT_W = $clog2(max3(HALF, CS_SETUP, CS_GAP) + 1);
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);
  // Remaining-bit count at the HIGH phase that completes the command byte of a write.
  localparam logic [4:0] WDATA_AT = 5'(SPI_WR_BITS - BYTE_BITS + 1);

  state_t           state, state_next;
  logic             accept, expire, tmr_load, last_bit, bit_done;
  logic [CNT_W-1:0] tmr_val;
  logic [4:0]       bit_cnt;
  logic [7:0]       shift_out, shift_in, wdata_q;
  logic             write_q;

  spi_mem_master_sclk_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (state != ST_IDLE),
    .expire   (expire)
  );

  assign accept   = req_valid && req_ready;
  assign last_bit = (bit_cnt == 5'd1);
  assign bit_done = (state == ST_HIGH) && expire;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_SETUP;
      ST_SETUP: if (expire) state_next = ST_LOW;
      ST_LOW:   if (expire) state_next = ST_HIGH;
      ST_HIGH:  if (expire) state_next = last_bit ? ST_GAP : ST_LOW;
      ST_GAP:   if (expire) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE) && !reset;
    busy      = (state != ST_IDLE);
    sclk_pin  = (state != ST_LOW);
    cs_pin    = (state == ST_IDLE) || (state == ST_GAP);
    mosi_pin  = ((state == ST_LOW) || (state == ST_HIGH)) ? shift_out[7] : 1'b0;
    tmr_load  = (state_next != state);
    case (state_next)
      ST_SETUP:        tmr_val = SETUP_LD;
      ST_LOW, ST_HIGH: tmr_val = HALF_LD;
      ST_GAP:          tmr_val = GAP_LD;
      default:         tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept)
        bit_cnt <= req_write ? 5'(SPI_WR_BITS) : 5'(SPI_RD_BITS);
      else if (bit_done)
        bit_cnt <= bit_cnt - 1'b1;
      // The final sample goes straight to the response so it lands in the first GAP cycle.
      if (bit_done && last_bit && !write_q) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= {shift_in[6:0], miso_pin};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q   <= req_write;
      wdata_q   <= req_wdata;
      shift_out <= {req_addr, req_write ? ~SPI_RW_READ : SPI_RW_READ};
    end else if (bit_done) begin
      shift_in <= {shift_in[6:0], miso_pin};
      if (write_q && (bit_cnt == WDATA_AT))
        shift_out <= wdata_q;
      else
        shift_out <= {shift_out[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed and randomized bench for spi_mem_master with a pin-level behavioural
// spiMemory slave and a byte-level expectation memory.
module tb_spi_mem_master;

  localparam int HALF     = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_GAP   = 4;
  localparam int WR_LEN   = CS_SETUP + 32 * HALF + CS_GAP;
  localparam int RD_LEN   = CS_SETUP + 34 * HALF + CS_GAP;
  localparam int RD_LAT   = CS_SETUP + 34 * HALF;
  localparam int BUDGET   = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy, sclk_pin, cs_pin, mosi_pin, miso_pin;

  spi_mem_master #(.HALF(HALF), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sclk_pin(sclk_pin), .cs_pin(cs_pin), .mosi_pin(mosi_pin), .miso_pin(miso_pin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 53 + 17) & 255);
  endfunction

  // Pin-level slave model and frame recorder.
  logic [7:0] smem [128];
  bit         smem_ready = 0;
  logic       prev_sclk = 1'b1, prev_cs = 1'b1;
  int         rises, cs_low;
  logic [7:0] cmd_sh, dat_sh;
  int         frames = 0, f_rises, f_cslow;
  logic [7:0] f_cmd, f_dat;
  int         rsp_cnt = 0, rsp_cyc = 0, acc_cnt = 0;
  logic [7:0] rsp_last;

  always @(negedge clk) begin
    logic [7:0] b;
    int         idx;
    if (!smem_ready) begin
      for (int i = 0; i < 128; i++) smem[i] = init_byte(i);
      smem_ready = 1;
      miso_pin = 1'b0;
      rises = 0; cs_low = 0; cmd_sh = '0; dat_sh = '0;
    end
    if (cs_pin) begin
      if (!prev_cs) begin
        frames++;
        f_cmd = cmd_sh; f_dat = dat_sh; f_rises = rises; f_cslow = cs_low;
        if (rises == 16 && cmd_sh[0] == 1'b0) smem[cmd_sh[7:1]] = dat_sh;
      end
      rises = 0; cs_low = 0; cmd_sh = '0; dat_sh = '0; miso_pin = 1'b0;
    end else begin
      cs_low++;
      if (sclk_pin && !prev_sclk) begin
        rises++;
        if (rises <= 8) cmd_sh = {cmd_sh[6:0], mosi_pin};
        else dat_sh = {dat_sh[6:0], mosi_pin};
      end
      if (!sclk_pin && prev_sclk && cmd_sh[0] && rises >= 9 && rises <= 16) begin
        b = smem[cmd_sh[7:1]];
        idx = 16 - rises;
        miso_pin = b[idx[2:0]];
      end
    end
    prev_sclk = sclk_pin;
    prev_cs = cs_pin;
    if (rsp_valid) begin
      rsp_cnt++; rsp_last = rsp_rdata; rsp_cyc = cyc;
    end
    if (req_valid && req_ready) acc_cnt++;
  end

  int         n_checks = 0, n_fails = 0;
  logic [7:0] ref_mem [128];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, output int acc_at);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < BUDGET) begin tick(); n++; end
    check("req_ready_wait", req_ready, 1);
    tick();
    acc_at = cyc;
    req_valid = 1'b0;
    req_write = $urandom_range(0, 1); req_addr = 7'($urandom); req_wdata = 8'($urandom);
  endtask

  task automatic wait_idle(output int fall_at);
    int n;
    n = 0;
    while (busy && n < BUDGET) begin tick(); n++; end
    check("busy_fall", busy, 0);
    fall_at = cyc;
  endtask

  task automatic do_txn(input logic w, input logic [6:0] a, input logic [7:0] d,
                        output int acc_at, output int fall_at);
    int fr0, rs0;
    fr0 = frames; rs0 = rsp_cnt;
    send(w, a, d, acc_at);
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", req_ready, 0);
    wait_idle(fall_at);
    check("frame_len", fall_at - acc_at, w ? WR_LEN : RD_LEN);
    check("frame_count", frames, fr0 + 1);
    check("cmd_byte", f_cmd, {a, ~w});
    check("rising_edges", f_rises, w ? 16 : 17);
    check("cs_low_cycles", f_cslow, CS_SETUP + (w ? 32 : 34) * HALF);
    check("mosi_after_cmd", f_dat, w ? d : 8'h00);
    if (w) begin
      check("no_rsp_on_write", rsp_cnt, rs0);
      ref_mem[a] = d;
    end else begin
      check("rsp_pulses", rsp_cnt, rs0 + 1);
      check("rsp_data", rsp_last, ref_mem[a]);
      check("rsp_latency", rsp_cyc - acc_at, RD_LAT);
      check("rsp_rdata_held", rsp_rdata, ref_mem[a]);
    end
  endtask

  initial begin
    int acc1, fall1, acc2, fall2, n, ready_bad, acc0, rs0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_byte(i);
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset state
    tick();
    check("rst_sclk", sclk_pin, 1);
    check("rst_cs", cs_pin, 1);
    check("rst_mosi", mosi_pin, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("ready_after_release", req_ready, 1);

    // Write 0xFF to 0x00, read it back
    do_txn(1'b1, 7'h00, 8'hFF, acc1, fall1);
    do_txn(1'b0, 7'h00, 8'h00, acc1, fall1);

    // Back-to-back write/read of 0x7F
    do_txn(1'b1, 7'h7F, 8'hA5, acc1, fall1);
    do_txn(1'b0, 7'h7F, 8'h00, acc2, fall2);
    check("back_to_back_accept", acc2 - fall1, 1);

    // req_valid held through a whole write
    acc0 = acc_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h15; req_wdata = 8'h3C;
    tick();
    ready_bad = 0; n = 0;
    while (busy && n < BUDGET) begin
      if (req_ready) ready_bad++;
      tick(); n++;
    end
    req_valid = 1'b0;
    check("hold_busy_fall", busy, 0);
    check("hold_ready_low", ready_bad, 0);
    check("hold_one_accept", acc_cnt, acc0 + 1);
    ref_mem[7'h15] = 8'h3C;
    check("hold_written", smem[7'h15], 8'h3C);

    // Reset in the middle of a read
    rs0 = rsp_cnt;
    send(1'b0, 7'h00, 8'h00, acc1);
    n = 0;
    while (rises < 9 && n < BUDGET) begin tick(); n++; end
    check("reached_bit9", rises >= 9, 1);
    reset = 1'b1;
    tick();
    check("midrst_cs", cs_pin, 1);
    check("midrst_sclk", sclk_pin, 1);
    check("midrst_mosi", mosi_pin, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("midrst_ready", req_ready, 1);
    check("midrst_no_rsp", rsp_cnt, rs0);
    do_txn(1'b0, 7'h00, 8'h00, acc1, fall1);

    // Randomized transactions
    for (int t = 0; t < 10; t++) begin
      logic       w;
      logic [6:0] a;
      logic [7:0] d;
      w = 1'($urandom_range(0, 1));
      a = (t < 4) ? 7'($urandom_range(0, 3)) : 7'($urandom);
      d = 8'($urandom);
      do_txn(w, a, d, acc1, fall1);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
